// File: rtl/idex_stage.sv
// ID/EX pipeline register with MEM/WB->EX operand forwarding and load-use
// hazard detection for the 5-stage RISC-V core.
module idex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_d,
  input  logic [RADDR-1:0] rs1_d,
  input  logic [RADDR-1:0] rs2_d,
  input  logic [RADDR-1:0] rd_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  immext_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic             alusrc_d,
  input  logic [2:0]       alucontrol_d,
  input  logic             regwrite_d,
  input  logic             memwrite_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic [1:0]       resultsrc_d,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [RADDR-1:0] rd_m,
  input  logic [RADDR-1:0] rd_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic [XLEN-1:0]  aluresult_m,
  input  logic [XLEN-1:0]  result_w,
  output logic [XLEN-1:0]  srca_e,
  output logic [XLEN-1:0]  srcb_e,
  output logic [XLEN-1:0]  writedata_e,
  output logic [2:0]       alucontrol_e,
  output logic [RADDR-1:0] rs1_e,
  output logic [RADDR-1:0] rs2_e,
  output logic [RADDR-1:0] rd_e,
  output logic [XLEN-1:0]  immext_e,
  output logic [XLEN-1:0]  pc_e,
  output logic             regwrite_e,
  output logic             memwrite_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic             valid_e,
  output logic [1:0]       resultsrc_e,
  output logic             lwstall
);

  typedef struct packed {
    logic             valid;
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rs2;
    logic [RADDR-1:0] rd;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  immext;
    logic [XLEN-1:0]  pc;
    logic             alusrc;
    logic [2:0]       alucontrol;
    logic             regwrite;
    logic             memwrite;
    logic             branch;
    logic             jump;
    logic [1:0]       resultsrc;
  } idex_t;

  idex_t q, d;

  always_comb begin
    d            = '0;
    d.valid      = valid_d;
    d.rs1        = rs1_d;
    d.rs2        = rs2_d;
    d.rd         = rd_d;
    d.rd1        = rd1_d;
    d.rd2        = rd2_d;
    d.immext     = immext_d;
    d.pc         = pc_d;
    d.alusrc     = alusrc_d;
    d.alucontrol = alucontrol_d;
    d.regwrite   = regwrite_d;
    d.memwrite   = memwrite_d;
    d.branch     = branch_d;
    d.jump       = jump_d;
    d.resultsrc  = resultsrc_d;
  end

  // A bubble clears data fields too, so a squashed slot never leaks stale operands.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!reset_n)      q <= '0;
    else if (flush_e)  q <= '0;
    else if (!stall_e) begin
      if (lwstall) q <= '0;
      else         q <= d;
    end
  end

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd(
    input logic [RADDR-1:0] rs,
    input logic [XLEN-1:0]  regval,
    input logic             we_m,
    input logic [RADDR-1:0] dst_m,
    input logic [XLEN-1:0]  val_m,
    input logic             we_w,
    input logic [RADDR-1:0] dst_w,
    input logic [XLEN-1:0]  val_w
  );
    if (we_m && dst_m != '0 && dst_m == rs)      return val_m;
    else if (we_w && dst_w != '0 && dst_w == rs) return val_w;
    else                                         return regval;
  endfunction

  always_comb begin
    srca_e      = fwd(q.rs1, q.rd1, regwrite_m, rd_m, aluresult_m, regwrite_w, rd_w, result_w);
    writedata_e = fwd(q.rs2, q.rd2, regwrite_m, rd_m, aluresult_m, regwrite_w, rd_w, result_w);
    srcb_e      = q.alusrc ? q.immext : writedata_e;
  end

  assign lwstall = q.valid && (q.resultsrc == 2'b01) && (q.rd != '0) && valid_d &&
                   ((q.rd == rs1_d) || (q.rd == rs2_d));

  assign alucontrol_e = q.alucontrol;
  assign rs1_e        = q.rs1;
  assign rs2_e        = q.rs2;
  assign rd_e         = q.rd;
  assign immext_e     = q.immext;
  assign pc_e         = q.pc;
  assign regwrite_e   = q.regwrite;
  assign memwrite_e   = q.memwrite;
  assign branch_e     = q.branch;
  assign jump_e       = q.jump;
  assign valid_e      = q.valid;
  assign resultsrc_e  = q.resultsrc;

endmodule

// File: tb/tb_idex_stage.sv
// Directed self-checking bench for idex_stage: reset, forwarding priority,
// immediate path, load-use bubble, stall and flush behaviour.
module tb_idex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [31:0] rd1_d, rd2_d, immext_d, pc_d;
  logic        alusrc_d;
  logic [2:0]  alucontrol_d;
  logic        regwrite_d, memwrite_d, branch_d, jump_d;
  logic [1:0]  resultsrc_d;
  logic        stall_e, flush_e;
  logic [4:0]  rd_m, rd_w;
  logic        regwrite_m, regwrite_w;
  logic [31:0] aluresult_m, result_w;
  logic [31:0] srca_e, srcb_e, writedata_e;
  logic [2:0]  alucontrol_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] immext_e, pc_e;
  logic        regwrite_e, memwrite_e, branch_e, jump_e, valid_e;
  logic [1:0]  resultsrc_e;
  logic        lwstall;

  int passed = 0;
  int total  = 0;

  idex_stage dut (
    .clk(clk), .reset_n(reset_n), .valid_d(valid_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .immext_d(immext_d), .pc_d(pc_d), .alusrc_d(alusrc_d), .alucontrol_d(alucontrol_d),
    .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .branch_d(branch_d), .jump_d(jump_d),
    .resultsrc_d(resultsrc_d), .stall_e(stall_e), .flush_e(flush_e),
    .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .aluresult_m(aluresult_m), .result_w(result_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .writedata_e(writedata_e), .alucontrol_e(alucontrol_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .immext_e(immext_e), .pc_e(pc_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .branch_e(branch_e), .jump_e(jump_e),
    .valid_e(valid_e), .resultsrc_e(resultsrc_e), .lwstall(lwstall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic asrc,
                       input logic [2:0] actl, input logic rw, input logic [1:0] rsrc);
    valid_d = v; rs1_d = r1; rs2_d = r2; rd_d = rd; rd1_d = d1; rd2_d = d2;
    immext_d = imm; pc_d = pc; alusrc_d = asrc; alucontrol_d = actl;
    regwrite_d = rw; memwrite_d = 1'b0; branch_d = 1'b0; jump_d = 1'b0; resultsrc_d = rsrc;
  endtask

  task automatic clear_fwd();
    rd_m = 0; rd_w = 0; regwrite_m = 0; regwrite_w = 0; aluresult_m = 0; result_w = 0;
  endtask

  initial begin
    reset_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    clear_fwd();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00);
    #12;
    check("reset_valid", valid_e, 0);
    check("reset_srca", srca_e, 0);
    check("reset_lwstall", lwstall, 0);
    reset_n = 1'b1;

    // Hold a load, then reset asynchronously mid-cycle
    set_d(1, 1, 0, 5, 32'h1, 0, 32'h4, 32'h40, 1, 3'b000, 1, 2'b01);
    tick();
    set_d(1, 5, 1, 6, 32'h0, 32'h3, 0, 32'h44, 0, 3'b000, 1, 2'b00);
    #1;
    check("pre_reset_lwstall", lwstall, 1);
    reset_n = 1'b0;
    #1;
    check("midreset_valid", valid_e, 0);
    check("midreset_lwstall", lwstall, 0);
    check("midreset_srca", srca_e, 0);
    check("midreset_srcb", srcb_e, 0);
    check("midreset_rd", rd_e, 0);
    check("midreset_ctl", {regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e}, 0);

    // add x3,x1,x2
    set_d(1, 1, 2, 3, 32'd5, 32'd7, 0, 32'h48, 0, 3'b000, 1, 2'b00);
    reset_n = 1'b1;
    tick();
    check("add_srca", srca_e, 5);
    check("add_srcb", srcb_e, 7);
    check("add_aluctl", alucontrol_e, 3'b000);
    check("add_rd", rd_e, 3);
    check("add_valid", valid_e, 1);

    // Forwarding priority on rs1=4
    set_d(1, 4, 0, 8, 32'h44, 0, 0, 32'h4c, 0, 3'b001, 1, 2'b00);
    tick();
    rd_m = 4; regwrite_m = 1; aluresult_m = 32'h11;
    rd_w = 4; regwrite_w = 1; result_w = 32'h22;
    #1;
    check("fwd_mem_wins", srca_e, 32'h11);
    regwrite_m = 0;
    #1;
    check("fwd_wb", srca_e, 32'h22);
    regwrite_w = 0;
    #1;
    check("fwd_none", srca_e, 32'h44);
    check("fwd_aluctl", alucontrol_e, 3'b001);

    // x0 is never forwarded
    set_d(1, 0, 0, 8, 32'h55, 32'h66, 0, 32'h50, 0, 3'b000, 1, 2'b00);
    tick();
    rd_m = 0; regwrite_m = 1; aluresult_m = 32'hdead;
    rd_w = 0; regwrite_w = 1; result_w = 32'hbeef;
    #1;
    check("x0_srca", srca_e, 32'h55);
    check("x0_wdata", writedata_e, 32'h66);
    clear_fwd();

    // Immediate path with forwarded rs2
    set_d(1, 0, 7, 2, 0, 32'h1, 32'hFFFF_FFF0, 32'h54, 1, 3'b000, 1, 2'b00);
    tick();
    rd_m = 7; regwrite_m = 1; aluresult_m = 32'h99;
    #1;
    check("imm_srcb", srcb_e, 32'hFFFF_FFF0);
    check("imm_wdata", writedata_e, 32'h99);
    clear_fwd();

    // Load-use: lw x5 followed by add x6,x5,x1
    set_d(1, 2, 0, 5, 0, 0, 32'h8, 32'h58, 1, 3'b000, 1, 2'b01);
    tick();
    set_d(1, 5, 1, 6, 32'h0, 32'h3, 0, 32'h5c, 0, 3'b000, 1, 2'b00);
    #1;
    check("lu_lwstall", lwstall, 1);
    tick();
    check("lu_bubble_valid", valid_e, 0);
    check("lu_bubble_ctl", {regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e}, 0);
    check("lu_bubble_rd", rd_e, 0);
    check("lu_bubble_pc", pc_e, 0);
    check("lu_drop", lwstall, 0);
    tick();
    check("lu_capture_rd", rd_e, 6);
    check("lu_capture_valid", valid_e, 1);
    rd_w = 5; regwrite_w = 1; result_w = 32'hABCD;
    #1;
    check("lu_wb_fwd", srca_e, 32'hABCD);
    check("lu_srcb", srcb_e, 32'h3);
    clear_fwd();

    // Load to x0 never stalls
    set_d(1, 2, 0, 0, 0, 0, 32'h8, 32'h60, 1, 3'b000, 1, 2'b01);
    tick();
    set_d(1, 0, 0, 6, 0, 0, 0, 32'h64, 0, 3'b000, 1, 2'b00);
    #1;
    check("lu_x0_lwstall", lwstall, 0);

    // Stall holds for 3 cycles while D changes
    set_d(1, 1, 2, 9, 32'h1, 32'h2, 32'h20, 32'h100, 1, 3'b101, 1, 2'b00);
    branch_d = 1;
    tick();
    stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      set_d(1, 3, 4, 5'(10 + i), 32'h7, 32'h8, 32'h30, 32'h200 + i, 0, 3'b010, 0, 2'b10);
      tick();
      check("stall_rd", rd_e, 9);
      check("stall_pc", pc_e, 32'h100);
      check("stall_ctl", {alucontrol_e, branch_e, regwrite_e}, {3'b101, 1'b1, 1'b1});
    end
    flush_e = 1;
    tick();
    check("flush_stall_valid", valid_e, 0);
    check("flush_stall_pc", pc_e, 0);
    check("flush_stall_aluctl", alucontrol_e, 0);
    flush_e = 0; stall_e = 0;

    // Stall with a pending load-use: hold, lwstall stays high
    set_d(1, 2, 0, 5, 0, 0, 32'h8, 32'h300, 1, 3'b000, 1, 2'b01);
    tick();
    set_d(1, 5, 0, 7, 0, 0, 0, 32'h304, 0, 3'b000, 1, 2'b00);
    stall_e = 1;
    tick();
    check("stall_lu_rd", rd_e, 5);
    check("stall_lu_lwstall1", lwstall, 1);
    tick();
    check("stall_lu_lwstall2", lwstall, 1);
    stall_e = 0;
    tick();
    check("stall_lu_bubble", valid_e, 0);
    check("stall_lu_drop", lwstall, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline register and execute-stage operand front end for the 5-stage RISC-V core. Captures decoded operands and control from the decode stage, applies MEM→EX and WB→EX forwarding, and drives the two ALU operands and the 3-bit ALU control into the execute-stage ALU. Also detects load-use hazards against the instruction it holds and inserts the required bubble.

## Interface
- XLEN, 32, datapath width
- RADDR, 5, register index width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- valid_d  in  1  decode slot holds a real instruction
- rs1_d, rs2_d, rd_d  in  RADDR  source and destination indices
- rd1_d, rd2_d  in  XLEN  register-file read data
- immext_d, pc_d  in  XLEN  extended immediate, instruction PC
- alusrc_d  in  1  1 = operand B is the immediate
- alucontrol_d  in  3  ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
- regwrite_d, memwrite_d, branch_d, jump_d  in  1  control bits
- resultsrc_d  in  2  00 ALU, 01 load, 10 PC+4
- stall_e  in  1  hold the stage (downstream freeze)
- flush_e  in  1  replace the captured instruction with a bubble
- rd_m, rd_w  in  RADDR  MEM/WB destination indices
- regwrite_m, regwrite_w  in  1  MEM/WB write enables
- aluresult_m, result_w  in  XLEN  forwarding data
- srca_e, srcb_e  out  XLEN  ALU operands
- writedata_e  out  XLEN  forwarded rs2 value for stores
- alucontrol_e  out  3  ALU control
- rs1_e, rs2_e, rd_e  out  RADDR  held indices
- immext_e, pc_e  out  XLEN  held immediate and PC
- regwrite_e, memwrite_e, branch_e, jump_e, valid_e  out  1  held control
- resultsrc_e  out  2  held result select
- lwstall  out  1  load-use hazard; upstream must stall F and D this cycle

## Operation
- Register update priority each rising edge: flush_e → bubble; else stall_e → hold; else lwstall → bubble; else capture all *_d inputs.
- Bubble: every held field, including data fields, loads 0 (valid 0, control 0, indices 0, alucontrol 000).
- Forward select per source (rs1_e, rs2_e), combinational:
  - MEM: regwrite_m & rd_m≠0 & rd_m==rsX_e → aluresult_m.
  - else WB: regwrite_w & rd_w≠0 & rd_w==rsX_e → result_w.
  - else held register-file data.
  - MEM beats WB when both match; index 0 is never forwarded.
- srca_e = forwarded rs1 value; writedata_e = forwarded rs2 value; srcb_e = alusrc_e ? immext_e : writedata_e.
- lwstall = valid_e & resultsrc_e==01 & rd_e≠0 & valid_d & (rd_e==rs1_d | rd_e==rs2_d). Depends only on held state and D inputs, never on forwarding inputs.
- Stage does not interpret alucontrol; it is passed unchanged.

## Timing
- Reset (async assert, sync-safe deassert): all held fields 0; outputs therefore srca_e=srcb_e=writedata_e=0, alucontrol_e=000, all control outputs 0, lwstall=0. Reset mid-operation discards the held instruction immediately.
- Capture latency 1 cycle: D inputs at edge N appear on *_e outputs after edge N.
- Forwarding is zero-latency: srca_e/srcb_e/writedata_e follow rd_m/rd_w/aluresult_m/result_w in the same cycle.
- Load-use: lwstall asserted the cycle the dependent instruction is in D; next edge inserts one bubble, load leaves to MEM, lwstall drops; dependent instruction captured on following edge and receives the load data via WB forwarding.
- flush_e with stall_e: flush wins. stall_e with lwstall: hold; lwstall stays high until stall_e releases.
- stall_e holds indefinitely; forwarded operands may change while held.

## Test plan
- Reset: reset_n=0 mid-stream with valid instruction held → all outputs 0 immediately, lwstall=0; release, capture add x3,x1,x2 (rd1=5, rd2=7) → srca_e=5, srcb_e=7, alucontrol_e=000, rd_e=3.
- Forward priority: rs1_e=4, rd_m=4/regwrite_m=1/aluresult_m=0x11, rd_w=4/regwrite_w=1/result_w=0x22 → srca_e=0x11; drop regwrite_m → 0x22; rd_m=rd_w=0 with rs1_e=0 → register value.
- Immediate path: alusrc_d=1, immext=0xFFFFFFF0, rs2 forwarded 0x99 → srcb_e=0xFFFFFFF0, writedata_e=0x99.
- Load-use: held lw x5 (resultsrc_e=01); D = add x6,x5,x1 → lwstall=1; next edge valid_e=0, all control 0; next edge add captured, with rd_w=5 forwarding result_w → srca_e=result_w. Same case with rd_e=0 → lwstall=0.
- Stall/flush: stall_e=1 for 3 cycles with changing D inputs → outputs unchanged; stall_e=1 and flush_e=1 together → bubble on next edge.
